bcd_time_counter: RTL
=====================

Name: bcd_time_counter

Overview:
- Downstream time-keeping stage of the digital clock: consumes the 1 Hz enable strobe from the prescaler/enable counter chain and keeps hours:minutes:seconds as six BCD digits for the display mux.
- Provides a set mode in which the user increments minutes or hours from a push-button, without carry into the next field.
- All state lives on one clock with an asynchronous active-low clear, matching the rest of the clock datapath.

Parameters:
- SEC_INIT, 0, reset value of seconds (binary 0-59; converted to BCD at reset).
- MIN_INIT, 0, reset value of minutes (binary 0-59).
- HR_INIT, 0, reset value of hours (binary 0-23).

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous active-low reset
- en  in  1  global count enable; 0 freezes time in both modes
- tick  in  1  one-cycle 1 Hz strobe from upstream counter
- set_mode  in  1  1 = SET state, 0 = RUN state
- set_sel  in  1  field in SET: 0 = minutes, 1 = hours
- inc  in  1  increment button level, already debounced
- sec_ones, sec_tens  out  4 each  BCD seconds
- min_ones, min_tens  out  4 each  BCD minutes
- hr_ones, hr_tens  out  4 each  BCD hours
- min_carry  out  1  one-cycle pulse on seconds wrap 59->00
- hr_carry  out  1  one-cycle pulse on minutes wrap 59->00 caused by counting
- day_carry  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
- pm  out  1  PM flag (see Optional Feature)

Behaviour:
- Reset (clear = 0, asynchronous):
  - Digits load the INIT values in BCD; defaults give 00:00:00.
  - All carry outputs = 0, pm = 0, inc edge register = 0, state = RUN.
- State machine, two states, registered:
  - RUN -> SET on set_mode = 1.
  - SET -> RUN on set_mode = 0.
  - A transition takes effect on the next rising clock edge. A tick arriving in the same cycle as a state change is processed according to the old state.
- RUN:
  - On a rising edge with en & tick: sec_ones increments.
  - 9 -> 0 increments sec_tens. Seconds 59 -> 00 increments minutes and pulses min_carry.
  - Minutes 59 -> 00 increments hours and pulses hr_carry.
  - Hours 23 -> 00 with minutes and seconds also wrapping pulses day_carry.
  - All digits affected by one tick update in that same edge (single-cycle ripple, no multi-cycle propagation).
  - Carry pulses are registered: high exactly the cycle after the tick edge, for one cycle.
  - The inc input is ignored in RUN.
- SET:
  - tick is ignored; seconds are held at 00, forced on entry to SET.
  - inc is edge-detected internally; one increment per 0->1 transition of inc, applied when en = 1.
  - set_sel = 0: minutes +1, 59 -> 00, no hour change, no carry pulses.
  - set_sel = 1: hours +1, 23 -> 00, no carry pulses.
  - inc held high produces no repeats. A rising edge of inc while en = 0 is lost.
- en = 0 holds all digits and suppresses all carry pulses. The state machine still follows set_mode.
- BCD invariant: digits never leave their legal ranges.
  - Tens of seconds/minutes 0-5, hr_tens 0-2, hr_ones 0-3 when hr_tens = 2.
  - Illegal INIT values are clamped to 0 at elaboration.
- Reset asserted mid-operation aborts any pending carry pulse. Outputs take reset values in the same cycle clear falls.

Optional Feature:
- Macro H12_MODE_EN.
- Defined:
  - Hours count 12, 01 .. 11 in BCD.
  - 11:59:59 -> 12:00:00 toggles pm. day_carry pulses only on the PM -> AM transition.
  - Reset gives 12:00:00 with pm = 0, and HR_INIT is ignored.
  - In SET, hour increment 11 -> 12 toggles pm; 12 -> 01 does not.
- Undefined: 24-hour operation as above; pm is tied to 0.

Test Plan:
- Reset with defaults, then 60 ticks (en = 1) -> time 00:01:00; min_carry high exactly once, one cycle after the 60th tick edge.
- HR_INIT = 23, MIN_INIT = 59, SEC_INIT = 58, two ticks -> 23:59:59, then 00:00:00; min_carry, hr_carry and day_carry all pulse on the same cycle.
- SET with set_sel = 0 from 00:58:xx, three inc pulses -> minutes 59, 00, 01; hours stay 00; seconds read 00; no carry pulses.
- SET with inc held high for 20 cycles plus tick strobes -> exactly one hour increment; digits otherwise unchanged.
- en = 0 for 10 ticks, then en = 1 for 1 tick -> advance by exactly 1 second.
- clear pulsed low mid-carry at 00:00:59 + tick -> outputs immediately 00:00:00 and no min_carry pulse.
- With H12_MODE_EN: reset, run to 11:59:59 + tick -> 12:00:00 with pm = 1; day_carry = 0.

Source files
------------

// File: rtl/bcd_time_counter.sv
// Time-of-day counter: hh:mm:ss as six BCD digits, with a RUN mode and a SET mode.
// Defining H12_MODE_EN selects a 12-hour display with a pm flag. Without it the counter runs 24-hour and pm is 0.
module bcd_time_counter #(
   parameter int SEC_INIT = 0,
   parameter int MIN_INIT = 0,
   parameter int HR_INIT  = 0
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       en,
   input  logic       tick,
   input  logic       set_mode,
   input  logic       set_sel,
   input  logic       inc,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] hr_tens,
   output logic       min_carry,
   output logic       hr_carry,
   output logic       day_carry,
   output logic       pm
);
   typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

   localparam int SEC_C = (SEC_INIT >= 0 && SEC_INIT <= 59) ? SEC_INIT : 0;
   localparam int MIN_C = (MIN_INIT >= 0 && MIN_INIT <= 59) ? MIN_INIT : 0;
   localparam logic [7:0] SEC_RST = 8'(((SEC_C / 10) * 16) + (SEC_C % 10));
   localparam logic [7:0] MIN_RST = 8'(((MIN_C / 10) * 16) + (MIN_C % 10));
`ifdef H12_MODE_EN
   localparam logic [7:0] HR_RST = 8'h12;
`else
   localparam int HR_C = (HR_INIT >= 0 && HR_INIT <= 23) ? HR_INIT : 0;
   localparam logic [7:0] HR_RST = 8'(((HR_C / 10) * 16) + (HR_C % 10));
`endif

   // Fields are held as {tens, ones} BCD bytes.
   function automatic logic [7:0] inc_sexa(input logic [7:0] v);
      if (v == 8'h59) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc_hour(input logic [7:0] v);
`ifdef H12_MODE_EN
      if (v == 8'h12) return 8'h01;
`else
      if (v == 8'h23) return 8'h00;
`endif
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   state_t     state_q, state_d;
   logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
   logic       inc_prev_q, inc_prev_d;
   logic       min_carry_q, min_carry_d, hr_carry_q, hr_carry_d;
   logic       day_carry_q, day_carry_d;
   logic       pm_q, pm_d;
   logic       run_tick, set_active, set_step, hr_step;

   // Mode decisions use the registered state, so a tick in a switching cycle obeys the old mode.
   assign run_tick   = en & tick & (state_q == ST_RUN);
   assign set_active = en & (state_q == ST_SET);
   assign set_step   = set_active & inc & ~inc_prev_q;
   assign hr_step    = hr_carry_d | (set_step & set_sel);

   always_comb begin
      state_d     = set_mode ? ST_SET : ST_RUN;
      inc_prev_d  = inc;
      sec_d       = sec_q;
      min_d       = min_q;
      hr_d        = hr_q;
      pm_d        = pm_q;
      min_carry_d = run_tick & (sec_q == 8'h59);
      hr_carry_d  = min_carry_d & (min_q == 8'h59);
      day_carry_d = 1'b0;

      if (run_tick) sec_d = inc_sexa(sec_q);
      // While setting, the seconds field is parked at zero.
      if (set_active) sec_d = 8'h00;
      if (min_carry_d || (set_step && !set_sel)) min_d = inc_sexa(min_q);
      if (hr_step) hr_d = inc_hour(hr_q);
`ifdef H12_MODE_EN
      if (hr_step && hr_q == 8'h11) pm_d = ~pm_q;
      day_carry_d = hr_carry_d & (hr_q == 8'h11) & pm_q;
`else
      pm_d        = 1'b0;
      day_carry_d = hr_carry_d & (hr_q == 8'h23);
`endif
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= ST_RUN;
         sec_q       <= SEC_RST;
         min_q       <= MIN_RST;
         hr_q        <= HR_RST;
         inc_prev_q  <= 1'b0;
         min_carry_q <= 1'b0;
         hr_carry_q  <= 1'b0;
         day_carry_q <= 1'b0;
         pm_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         inc_prev_q  <= inc_prev_d;
         min_carry_q <= min_carry_d;
         hr_carry_q  <= hr_carry_d;
         day_carry_q <= day_carry_d;
         pm_q        <= pm_d;
      end
   end

   assign {sec_tens, sec_ones} = sec_q;
   assign {min_tens, min_ones} = min_q;
   assign {hr_tens, hr_ones}   = hr_q;
   assign min_carry = min_carry_q;
   assign hr_carry  = hr_carry_q;
   assign day_carry = day_carry_q;
   assign pm        = pm_q;
endmodule
